// File: rtl/qspi_rsp_pkg.sv
// Shared types and command codes for the QSPI flash responder.
// Single-lane output shaping keeps the lanes the responder does not drive at 1.
package qspi_rsp_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
  typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_STATUS} src_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_QREAD = 8'h6B;
  localparam logic [7:0] CMD_RDID  = 8'h9F;
  localparam logic [7:0] CMD_RDSR  = 8'h05;

  function automatic logic [3:0] single_lanes(input logic b);
    return {2'b11, b, 1'b1};
  endfunction

endpackage

// File: rtl/qspi_rsp_sync.sv
// Two-flop synchronizers for SCLK/SS/TXD plus registered SCLK edge strobes.
// Pin-to-strobe latency is 3 clk cycles; ss and txd are delayed to stay aligned.
module qspi_rsp_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ss,
  input  logic [3:0] txd,
  output logic       ss_sync,
  output logic [3:0] txd_sync,
  output logic       sclk_rise,
  output logic       sclk_fall
);

  logic [1:0] sclk_m;
  logic [1:0] ss_m;
  logic [3:0] txd_m0;
  logic [3:0] txd_m1;
  logic       sclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_m    <= 2'b00;
      ss_m      <= 2'b11;
      txd_m0    <= 4'h0;
      txd_m1    <= 4'h0;
      sclk_d    <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ss_sync   <= 1'b1;
      txd_sync  <= 4'h0;
    end else begin
      sclk_m    <= {sclk_m[0], sclk};
      ss_m      <= {ss_m[0], ss};
      txd_m0    <= txd;
      txd_m1    <= txd_m0;
      sclk_d    <= sclk_m[1];
      sclk_rise <= sclk_m[1] & ~sclk_d;
      sclk_fall <= ~sclk_m[1] & sclk_d;
      // Third stage on ss/txd so they line up with the registered strobes
      ss_sync   <= ss_m[1];
      txd_sync  <= txd_m1;
    end
  end

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI NOR-flash emulator: decodes READ/QREAD/RDID/RDSR and shifts bytes out after SCLK falls.
// Output bit lands ~4 ppm_clk after SCLK fall; one-byte prefetch, 0xFF plus sticky underrun if it is empty.
module qspi_flash_responder
  import qspi_rsp_pkg::*;
#(
  parameter logic [23:0] DEVICE_ID  = 24'hEF4016,
  parameter int unsigned QUAD_DUMMY = 8,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic        ppm_clk,
  input  logic        rst_n,
  input  logic        qspi_sclk,
  input  logic        qspi_ss,
  input  logic [3:0]  qspi_txd,
  output logic [3:0]  qspi_rxd,
  output logic [3:0]  rsp_oe,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        underrun
);

  logic       ss_sync;
  logic [3:0] txd_sync;
  logic       sclk_rise;
  logic       sclk_fall;

  qspi_rsp_sync u_sync (
    .clk       (ppm_clk),
    .rst_n     (rst_n),
    .sclk      (qspi_sclk),
    .ss        (qspi_ss),
    .txd       (qspi_txd),
    .ss_sync   (ss_sync),
    .txd_sync  (txd_sync),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  logic [2:0] txd_unused;
  assign txd_unused = txd_sync[3:1];

  state_t      state;
  src_t        src;
  logic        quad;
  logic [4:0]  bit_cnt;
  logic [6:0]  cmd_sh;
  logic [22:0] addr_sh;
  logic [7:0]  buf_dat;
  logic        buf_vld;
  logic [7:0]  out_sh;
  logic [2:0]  out_cnt;
  logic [1:0]  id_idx;

  logic [7:0]  cmd_byte;
  logic [23:0] addr_full;
  logic [7:0]  next_byte;
  logic [2:0]  last_cnt;

  assign cmd_byte  = {cmd_sh, txd_sync[0]};
  assign addr_full = {addr_sh, txd_sync[0]};
  assign last_cnt  = quad ? 3'd1 : 3'd7;

  always_comb begin
    next_byte = 8'hFF;
    case (src)
      SRC_ID: begin
        case (id_idx)
          2'd0:    next_byte = DEVICE_ID[23:16];
          2'd1:    next_byte = DEVICE_ID[15:8];
          2'd2:    next_byte = DEVICE_ID[7:0];
          default: next_byte = 8'hFF;
        endcase
      end
      SRC_STATUS: next_byte = STATUS_VAL;
      default:    next_byte = buf_vld ? buf_dat : 8'hFF;
    endcase
  end

  always_ff @(posedge ppm_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src      <= SRC_MEM;
      quad     <= 1'b0;
      bit_cnt  <= 5'd0;
      cmd_sh   <= 7'd0;
      addr_sh  <= 23'd0;
      buf_dat  <= 8'h00;
      buf_vld  <= 1'b0;
      out_sh   <= 8'hFF;
      out_cnt  <= 3'd0;
      id_idx   <= 2'd0;
      qspi_rxd <= 4'hF;
      rsp_oe   <= 4'h0;
      mem_req  <= 1'b0;
      mem_addr <= 24'd0;
      underrun <= 1'b0;
    end else if (ss_sync) begin
      // Deselect wins over everything, including a coincident mem_ack
      state    <= IDLE;
      rsp_oe   <= 4'h0;
      qspi_rxd <= 4'hF;
      mem_req  <= 1'b0;
      buf_vld  <= 1'b0;
    end else begin
      if (mem_req && mem_ack) begin
        buf_dat <= mem_rdata;
        buf_vld <= 1'b1;
        mem_req <= 1'b0;
      end
      case (state)
        IDLE: begin
          state   <= CMD;
          bit_cnt <= 5'd0;
        end
        CMD: if (sclk_rise) begin
          cmd_sh  <= cmd_byte[6:0];
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            bit_cnt <= 5'd0;
            quad    <= (cmd_byte == CMD_QREAD);
            id_idx  <= 2'd0;
            out_cnt <= 3'd0;
            case (cmd_byte)
              CMD_READ, CMD_QREAD: begin state <= ADDR; src <= SRC_MEM;    end
              CMD_RDID:            begin state <= DATA; src <= SRC_ID;     end
              CMD_RDSR:            begin state <= DATA; src <= SRC_STATUS; end
              default:             state <= IGNORE;
            endcase
          end
        end
        ADDR: if (sclk_rise) begin
          addr_sh <= addr_full[22:0];
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd23) begin
            bit_cnt  <= 5'd0;
            mem_addr <= addr_full;
            mem_req  <= 1'b1;
            state    <= (quad && QUAD_DUMMY != 0) ? DUMMY : DATA;
          end
        end
        DUMMY: if (sclk_rise) begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'(QUAD_DUMMY - 1)) state <= DATA;
        end
        DATA: if (sclk_fall) begin
          rsp_oe <= quad ? 4'hF : 4'b0010;
          if (out_cnt == 3'd0) begin
            if (src == SRC_MEM) begin
              if (buf_vld) begin
                buf_vld  <= 1'b0;
                mem_addr <= mem_addr + 24'd1;
                mem_req  <= 1'b1;
              end else begin
                underrun <= 1'b1;
              end
            end
            if (src == SRC_ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            qspi_rxd <= quad ? next_byte[7:4] : single_lanes(next_byte[7]);
            out_sh   <= quad ? {next_byte[3:0], 4'hF} : {next_byte[6:0], 1'b1};
            out_cnt  <= 3'd1;
          end else begin
            qspi_rxd <= quad ? out_sh[7:4] : single_lanes(out_sh[7]);
            out_sh   <= quad ? {out_sh[3:0], 4'hF} : {out_sh[6:0], 1'b1};
            out_cnt  <= (out_cnt == last_cnt) ? 3'd0 : out_cnt + 3'd1;
          end
        end
        IGNORE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: acts as the QSPI master and a byte memory returning addr[7:0].
module tb_qspi_flash_responder;
  import qspi_rsp_pkg::*;

  localparam int HALF = 10;

  logic        ppm_clk;
  logic        rst_n;
  logic        qspi_sclk;
  logic        qspi_ss;
  logic [3:0]  qspi_txd;
  logic [3:0]  qspi_rxd;
  logic [3:0]  rsp_oe;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        underrun;

  qspi_flash_responder dut (
    .ppm_clk   (ppm_clk),
    .rst_n     (rst_n),
    .qspi_sclk (qspi_sclk),
    .qspi_ss   (qspi_ss),
    .qspi_txd  (qspi_txd),
    .qspi_rxd  (qspi_rxd),
    .rsp_oe    (rsp_oe),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .underrun  (underrun)
  );

  int          total  = 0;
  int          passed = 0;
  int          failed = 0;
  logic        hold   = 1'b0;
  logic        req_seen = 1'b0;
  logic [3:0]  oe_acc = 4'h0;
  int          mcnt   = 0;
  logic [23:0] fetch_q[$];

  initial ppm_clk = 1'b0;
  always #5 ppm_clk = ~ppm_clk;

  // Memory: acks two cycles after it sees a request, unless held off
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge ppm_clk);
      mem_ack = 1'b0;
      if (mem_req) req_seen = 1'b1;
      if (mem_req && !hold) begin
        mcnt++;
        if (mcnt == 2) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr[7:0];
          fetch_q.push_back(mem_addr);
          mcnt = 0;
        end
      end else begin
        mcnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fetch_at(input int i);
    if (i < fetch_q.size()) return 32'(fetch_q[i]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge ppm_clk);
  endtask

  task automatic sclk_cycle(input logic [3:0] t, output logic [3:0] r);
    qspi_txd = t;
    wait_clk(HALF);
    r = qspi_rxd;
    oe_acc = oe_acc | rsp_oe;
    qspi_sclk = 1'b1;
    wait_clk(HALF);
    qspi_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    logic [3:0] r;
    for (int i = n - 1; i >= 0; i--) sclk_cycle({3'b000, v[i]}, r);
  endtask

  task automatic read_single(output logic [7:0] b);
    logic [3:0] r;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sclk_cycle(4'h0, r);
      b = {b[6:0], r[1]};
    end
  endtask

  task automatic sel;
    qspi_ss = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic desel;
    qspi_ss = 1'b1;
    wait_clk(2 * HALF);
  endtask

  initial begin
    logic [7:0]  b;
    logic [3:0]  r;
    logic [3:0]  nib[6];
    logic [47:0] bits;
    logic [3:0]  exp_nib[6];

    exp_nib = '{4'hF, 4'hE, 4'hF, 4'hF, 4'h0, 4'h0};
    rst_n = 1'b0; qspi_sclk = 1'b0; qspi_ss = 1'b1; qspi_txd = 4'h0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    check("rst_rxd", 32'(qspi_rxd), 32'hF);
    check("rst_oe", 32'(rsp_oe), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);

    // Reset asserted mid-transfer with a fetch still pending
    hold = 1'b1;
    sel;
    send_bits(24'(CMD_READ), 8);
    send_bits(24'h000040, 24);
    sclk_cycle(4'h0, r);
    check("pre_rst_oe", 32'(rsp_oe), 32'h2);
    check("pre_rst_req", 32'(mem_req), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rxd", 32'(qspi_rxd), 32'hF);
    check("async_rst_oe", 32'(rsp_oe), 32'h0);
    check("async_rst_req", 32'(mem_req), 32'h0);
    check("async_rst_underrun", 32'(underrun), 32'h0);
    qspi_ss = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    hold = 1'b0;
    wait_clk(4);

    // Single read at 0x000010
    fetch_q.delete();
    sel;
    send_bits(24'(CMD_READ), 8);
    send_bits(24'h000010, 24);
    for (int i = 0; i < 4; i++) begin
      read_single(b);
      check($sformatf("read_byte%0d", i), 32'(b), 32'(8'h10 + i));
    end
    check("read_oe", 32'(rsp_oe), 32'h2);
    check("read_underrun", 32'(underrun), 32'h0);
    desel;
    check("desel_oe", 32'(rsp_oe), 32'h0);

    // Quad read across the address wrap
    fetch_q.delete();
    sel;
    send_bits(24'(CMD_QREAD), 8);
    send_bits(24'hFFFFFE, 24);
    for (int i = 0; i < 8; i++) sclk_cycle(4'h0, r);
    for (int i = 0; i < 6; i++) sclk_cycle(4'h0, nib[i]);
    check("qread_oe", 32'(rsp_oe), 32'hF);
    desel;
    for (int i = 0; i < 6; i++) check($sformatf("qread_nib%0d", i), 32'(nib[i]), 32'(exp_nib[i]));
    check("qread_fetch0", fetch_at(0), 32'hFFFFFE);
    check("qread_fetch1", fetch_at(1), 32'hFFFFFF);
    check("qread_fetch2", fetch_at(2), 32'h000000);

    // JEDEC ID
    req_seen = 1'b0;
    sel;
    send_bits(24'(CMD_RDID), 8);
    read_single(b); check("id_byte0", 32'(b), 32'hEF);
    check("id_idle_lanes", 32'(qspi_rxd & 4'b1101), 32'hD);
    read_single(b); check("id_byte1", 32'(b), 32'h40);
    read_single(b); check("id_byte2", 32'(b), 32'h16);
    read_single(b); check("id_byte3", 32'(b), 32'hFF);
    read_single(b); check("id_byte4", 32'(b), 32'hFF);
    desel;
    check("id_no_req", 32'(req_seen), 32'h0);

    // Read with the memory ack withheld for 40 SCLK periods
    hold = 1'b1;
    sel;
    send_bits(24'(CMD_READ), 8);
    send_bits(24'h000010, 24);
    bits = '0;
    for (int i = 0; i < 48; i++) begin
      if (i == 39) hold = 1'b0;
      sclk_cycle(4'h0, r);
      bits = {bits[46:0], r[1]};
    end
    check("late_byte0", 32'(bits[47:40]), 32'hFF);
    check("late_byte5", 32'(bits[7:0]), 32'h10);
    check("late_underrun", 32'(underrun), 32'h1);
    desel;

    // Unknown command, then an aborted READ, then status
    oe_acc = 4'h0;
    sel;
    send_bits(24'h00005A, 8);
    send_bits(24'h00A5C3, 16);
    desel;
    sel;
    send_bits(24'h000000, 3);
    desel;
    check("ignore_oe", 32'(oe_acc), 32'h0);
    check("abort_idle", 32'(dut.state), 32'(IDLE));
    check("abort_req", 32'(mem_req), 32'h0);
    sel;
    send_bits(24'(CMD_RDSR), 8);
    read_single(b); check("status_byte0", 32'(b), 32'h00);
    check("status_oe", 32'(rsp_oe), 32'h2);
    read_single(b); check("status_byte1", 32'(b), 32'h00);
    desel;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
